// File: rtl/lcd_arb_pkg.sv
// lcd_arb_pkg: shared FSM state encoding and LCD command codes for the LCD command arbiter.
package lcd_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
endpackage

// File: rtl/lcd_rr_arbiter.sv
// lcd_rr_arbiter: combinational round-robin pick.
// Ports: req (request vector), ptr (index where the search starts), gnt (one-hot grant, 0 if no request).
module lcd_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt
);
    int idx;
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: round-robin arbiter serialising byte writes from NUM_REQ requesters onto an HD44780-style LCD bus.
// Ports: clk, reset (sync, active-low), ready_i, req_i/rs_i/data_i per requester, gnt_o one-hot grant pulse,
// busy_o, lcd_rs/lcd_rw/lcd_e/lcd_data to the LCD. Define LCD_ARB_LOCK_EN to add lock_i (bus lock).
module lcd_cmd_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int EN_PULSE_CYC  = 8,
    parameter int CMD_WAIT_CYC  = 50,
    parameter int LONG_WAIT_CYC = 2000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   rs_i,
    input  logic [NUM_REQ*8-1:0] data_i,
`ifdef LCD_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   lock_i,
`endif
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic                 busy_o,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_e,
    output logic [7:0]           lcd_data
);
    localparam int CW = $clog2((EN_PULSE_CYC > LONG_WAIT_CYC ? EN_PULSE_CYC : LONG_WAIT_CYC) + 1);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, hold_end;
    logic [IW-1:0] last, ptr, gidx;
    logic last_vld, lng, take;
    logic [NUM_REQ-1:0] rr_gnt, gnt_sel;
    logic [7:0] sel_data;
    assign ptr = (!last_vld || int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
    lcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (.req(req_i), .ptr(ptr), .gnt(rr_gnt));
`ifdef LCD_ARB_LOCK_EN
    // A locked owner that still requests keeps the bus ahead of round-robin.
    assign gnt_sel = (last_vld && lock_i[last] && req_i[last]) ? NUM_REQ'(1) << last : rr_gnt;
`else
    assign gnt_sel = rr_gnt;
`endif
    assign take     = reset && state == IDLE && ready_i && |req_i;
    assign gnt_o    = take ? gnt_sel : '0;
    assign busy_o   = state != IDLE;
    assign lcd_e    = state == PULSE;
    assign lcd_rw   = 1'b0;
    assign sel_data = data_i[8*int'(gidx) +: 8];
    assign hold_end = lng ? CW'(LONG_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
    always_comb begin
        gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) if (gnt_sel[k]) gidx = IW'(k);
    end
    // Counter restarts at every phase boundary, so it never reaches its wrap point.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:  state_n = take ? SETUP : IDLE;
            SETUP: begin
                state_n = PULSE;
                cnt_n   = '0;
            end
            PULSE: begin
                state_n = cnt == CW'(EN_PULSE_CYC - 1) ? HOLD : PULSE;
                cnt_n   = cnt == CW'(EN_PULSE_CYC - 1) ? '0 : cnt + 1'b1;
            end
            HOLD: begin
                state_n = cnt == hold_end ? IDLE : HOLD;
                cnt_n   = cnt == hold_end ? '0 : cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= '0;
            last_vld <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            lng      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (take) begin
                last     <= gidx;
                last_vld <= 1'b1;
                lcd_rs   <= rs_i[gidx];
                lcd_data <= sel_data;
                lng      <= !rs_i[gidx] && (sel_data == LCD_CMD_CLEAR || sel_data == LCD_CMD_HOME);
            end
        end
    end
endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb_lcd_cmd_arbiter: checks lcd_cmd_arbiter against a transfer-timeline model plus directed literal expectations.
module tb_lcd_cmd_arbiter;
    localparam int N = 2, EN = 8, CW = 50, LW = 2000;
    logic clk = 0, reset = 0, ready_i = 1;
    logic [N-1:0] req_i = 0, rs_i = 0, lock_i = 0, gnt_o;
    logic [N*8-1:0] data_i = 0;
    logic busy_o, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    int total = 0, bad = 0, cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    lcd_cmd_arbiter #(.NUM_REQ(N), .EN_PULSE_CYC(EN), .CMD_WAIT_CYC(CW), .LONG_WAIT_CYC(LW)) dut (
        .clk(clk), .reset(reset), .ready_i(ready_i), .req_i(req_i), .rs_i(rs_i), .data_i(data_i),
`ifdef LCD_ARB_LOCK_EN
        .lock_i(lock_i),
`endif
        .gnt_o(gnt_o), .busy_o(busy_o), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data));
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask
    // Model: a transfer is a timeline anchored at its grant cycle g with hold length w.
    bit en = 0, have_g = 0, have_last = 0;
    int g = 0, w = 0, last = 0;
    logic m_rs = 0;
    logic [7:0] m_data = 0;
    always @(negedge clk) begin
        logic [N-1:0] eg;
        int t, ptr, pick;
        logic [7:0] d;
        t = cyc;
        eg = '0;
        pick = -1;
        if (reset && ready_i && |req_i && (!have_g || t >= g + 2 + EN + w)) begin
            ptr = have_last ? (last + 1) % N : 0;
            for (int k = 0; k < N; k++) if (pick < 0 && req_i[(ptr + k) % N]) pick = (ptr + k) % N;
`ifdef LCD_ARB_LOCK_EN
            if (have_last && lock_i[last] && req_i[last]) pick = last;
`endif
            eg[pick] = 1'b1;
        end
        if (en) begin
            chk("gnt", gnt_o, eg);
            chk("busy", busy_o, have_g && t > g && t <= g + 1 + EN + w);
            chk("e", lcd_e, have_g && t >= g + 2 && t <= g + 1 + EN);
            chk("rs", lcd_rs, m_rs);
            chk("data", lcd_data, m_data);
            chk("rw", lcd_rw, 0);
        end
        if (pick >= 0) begin
            d = data_i[8*pick +: 8];
            g = t;
            m_rs = rs_i[pick];
            m_data = d;
            w = (!rs_i[pick] && (d == 8'h01 || d == 8'h02)) ? LW : CW;
            last = pick;
            have_last = 1;
            have_g = 1;
        end
        if (!reset) begin
            have_g = 0;
            have_last = 0;
            m_rs = 0;
            m_data = 0;
            en = 1;
        end
    end
    task automatic drv(input logic [N-1:0] rq, input logic [N-1:0] rs, input logic [15:0] dt);
        @(posedge clk) #1;
        req_i = rq;
        rs_i = rs;
        data_i = dt;
    endtask
    task automatic wait_gnt(output int tg, output logic [N-1:0] v);
        tg = -1;
        v = 0;
        for (int i = 0; i < 3000 && tg < 0; i++) begin
            @(negedge clk);
            if (gnt_o != 0) begin
                tg = cyc;
                v = gnt_o;
            end
        end
        if (tg < 0) chk("gnt_timeout", 0, 1);
    endtask
    task automatic wait_idle(output int tf, output int ecnt, output logic l_rs, output logic [7:0] l_d);
        tf = -1;
        ecnt = 0;
        l_rs = 0;
        l_d = 0;
        for (int i = 0; i < 3000 && tf < 0; i++) begin
            @(negedge clk);
            if (lcd_e) ecnt++;
            if (busy_o) begin
                l_rs = lcd_rs;
                l_d = lcd_data;
            end else tf = cyc;
        end
        if (tf < 0) chk("idle_timeout", 0, 1);
    endtask
    initial begin
        int ta, tb, t2, t3, t4, t5, ec, ng;
        logic [N-1:0] v;
        logic lr;
        logic [7:0] ld;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_e", lcd_e, 0);
        drv(2'b01, 2'b01, 16'h0041);
        wait_gnt(ta, v);
        chk("a_gnt", v, 2'b01);
        drv(2'b00, 2'b01, 16'h0041);
        wait_idle(tb, ec, lr, ld);
        chk("a_busy_fall", tb - ta, 60);
        chk("a_e_cycles", ec, 8);
        chk("a_rs_hold", lr, 1);
        chk("a_data_hold", ld, 8'h41);
        drv(2'b01, 2'b00, 16'h0001);
        wait_gnt(ta, v);
        chk("b_gnt", v, 2'b01);
        drv(2'b10, 2'b10, 16'h5501);
        wait_gnt(t2, v);
        chk("b_long_gap", t2 - ta, 2010);
        chk("b_gnt2", v, 2'b10);
        drv(2'b11, 2'b11, 16'h5541);
        wait_gnt(t3, v);
        chk("c_gnt3", v, 2'b01);
        chk("c_gap3", t3 - t2, 60);
        wait_gnt(t4, v);
        chk("c_gnt4", v, 2'b10);
        chk("c_gap4", t4 - t3, 60);
        wait_gnt(t5, v);
        chk("c_gnt5", v, 2'b01);
        chk("c_gap5", t5 - t4, 60);
        @(posedge clk) #1 ready_i = 0;
        wait_idle(tb, ec, lr, ld);
        ng = 0;
        repeat (100) begin
            @(negedge clk);
            if (gnt_o != 0 || busy_o) ng++;
        end
        chk("d_blocked", ng, 0);
        @(posedge clk) #1 ready_i = 1;
        wait_gnt(ta, v);
        chk("d_rr_after_ready", v, 2'b10);
        drv(2'b00, 2'b11, 16'h5541);
        wait_idle(tb, ec, lr, ld);
        drv(2'b01, 2'b01, 16'h0033);
        wait_gnt(ta, v);
        chk("e_gnt", v, 2'b01);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("e_pulse_before", lcd_e, 1);
        @(posedge clk) #1 reset = 0;
        @(posedge clk);
        @(negedge clk);
        chk("e_rst_e", lcd_e, 0);
        chk("e_rst_busy", busy_o, 0);
        chk("e_rst_data", lcd_data, 8'h00);
        #1;
        drv(2'b11, 2'b11, 16'h5541);
        reset = 1;
        wait_gnt(ta, v);
        chk("e_first_after_rst", v, 2'b01);
`ifdef LCD_ARB_LOCK_EN
        lock_i = 2'b01;
        wait_gnt(ta, v);
        chk("f_lock1", v, 2'b01);
        wait_gnt(ta, v);
        chk("f_lock2", v, 2'b01);
        @(posedge clk) #1 lock_i = 2'b00;
        wait_gnt(ta, v);
        chk("f_unlock", v, 2'b10);
`endif
        drv(2'b00, 2'b11, 16'h5541);
        wait_idle(tb, ec, lr, ld);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
